mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 169 ++++++++++++++++
 tb/tb_mem_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Byte-wide memory slave with programmable wait states. A request is captured
// in IDLE, optionally delayed in WAIT, and completed on entry to HOLD, where
// READY stays high until the core drops MREQ.
//
// Optional feature: define MEM_RESPONDER_WPROT_EN to add parameter WPROT_LIMIT.
// Writes whose latched address is below WPROT_LIMIT then complete normally
// (READY, ACC_CNT) but leave the array untouched.
//
// Ports
//   CLK      in   single clock, rising edge
//   nRESET   in   asynchronous active-low reset
//   MREQ     in   memory request
//   RD, WR   in   read / write strobes (exactly one must be set to capture)
//   A        in   byte address, ADDR_W bits (upper bits mirror)
//   D        io   8-bit data bus, driven only while returning read data
//   READY    out  high exactly while in HOLD
//   BUS_ERR  out  sticky, set by MREQ with RD and WR both high in IDLE
//   ACC_CNT  out  16-bit count of completed accesses, wraps
//
// DEPTH_LOG2 must not exceed ADDR_W.
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int         ADDR_W      = 16,
  parameter int         DEPTH_LOG2  = 12,
  parameter int         WAIT_STATES = 0,
  parameter logic [7:0] FILL        = 8'h00
`ifdef MEM_RESPONDER_WPROT_EN
  ,
  parameter logic [15:0] WPROT_LIMIT = 16'h8000
`endif
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              MREQ,
  input  logic              RD,
  input  logic              WR,
  input  logic [ADDR_W-1:0] A,
  inout  wire  [7:0]        D,
  output logic              READY,
  output logic              BUS_ERR,
  output logic [15:0]       ACC_CNT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // state  | meaning
  // IDLE   | waiting for a legal request
  // WAIT   | request latched, counting down wait states
  // HOLD   | access done, READY high until MREQ drops
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                is_rd_q, is_rd_d;
  logic [7:0]          out_q, out_d;
  logic                err_q, err_d;
  logic [15:0]         acc_q, acc_d;
  logic                hold_entry;
  logic                mem_we;
  logic                wr_allowed;
  logic [DEPTH_LOG2-1:0] mem_idx;
  logic                d_oe;

  // Array contents are never reset; FILL is only the power-on image.
  logic [7:0] mem_q [DEPTH] = '{default: FILL};

  // Address bits above DEPTH_LOG2 mirror onto the array and are not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{A, addr_q};

  // The access always uses the address/direction that is being latched on
  // this edge (addr_d), so a zero-wait capture goes straight to the array.
  assign mem_idx = addr_d[DEPTH_LOG2-1:0];

`ifdef MEM_RESPONDER_WPROT_EN
  assign wr_allowed = (32'(addr_d) >= 32'(WPROT_LIMIT));
`else
  assign wr_allowed = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    is_rd_d    = is_rd_q;
    out_d      = out_q;
    err_d      = err_q;
    acc_d      = acc_q;
    hold_entry = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (MREQ && RD && WR) begin
          err_d = 1'b1;
        end else if (MREQ && (RD ^ WR)) begin
          addr_d  = A;
          is_rd_d = RD;
          if (WAIT_STATES == 0) begin
            state_d    = S_HOLD;
            hold_entry = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // <= 1 rather than == 1 so a corrupted zero count cannot stall here.
        if (cnt_q <= 4'd1) begin
          state_d    = S_HOLD;
          hold_entry = 1'b1;
          cnt_d      = 4'd0;
        end
      end
      S_HOLD: begin
        if (!MREQ) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (hold_entry) begin
      acc_d = acc_q + 16'd1;
      if (is_rd_d) out_d  = mem_q[mem_idx];
      else         mem_we = wr_allowed;
    end
  end

  // The array write sits in the reset-qualified branch so that an edge seen
  // while nRESET is low can never commit a write.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      is_rd_q <= 1'b0;
      out_q   <= 8'h00;
      err_q   <= 1'b0;
      acc_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      is_rd_q <= is_rd_d;
      out_q   <= out_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      if (mem_we) mem_q[mem_idx] <= D;
    end
  end

  // Read data is only returned while the core still asserts its read strobe.
  assign d_oe    = (state_q == S_HOLD) && is_rd_q && MREQ && RD;
  assign D       = d_oe ? out_q : 8'hzz;
  assign READY   = (state_q == S_HOLD);
  assign BUS_ERR = err_q;
  assign ACC_CNT = acc_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mreq [2];
  logic        rd   [2];
  logic        wr   [2];
  logic [15:0] addr [2];
  logic [7:0]  dout [2];
  logic        den  [2];
  logic        ready[2];
  logic        berr [2];
  logic [15:0] acnt [2];
  wire  [7:0]  d0;
  wire  [7:0]  d1;

  assign d0 = den[0] ? dout[0] : 8'hzz;
  assign d1 = den[1] ? dout[1] : 8'hzz;

  always #5 clk = ~clk;

  // Instance 0: zero wait states. Instance 1: three wait states.
  mem_responder #(.ADDR_W(16), .DEPTH_LOG2(12), .WAIT_STATES(0), .FILL(8'h00)) u_dut0 (
    .CLK(clk), .nRESET(rst_n), .MREQ(mreq[0]), .RD(rd[0]), .WR(wr[0]), .A(addr[0]),
    .D(d0), .READY(ready[0]), .BUS_ERR(berr[0]), .ACC_CNT(acnt[0]));

  mem_responder #(.ADDR_W(16), .DEPTH_LOG2(12), .WAIT_STATES(3), .FILL(8'h00)) u_dut1 (
    .CLK(clk), .nRESET(rst_n), .MREQ(mreq[1]), .RD(rd[1]), .WR(wr[1]), .A(addr[1]),
    .D(d1), .READY(ready[1]), .BUS_ERR(berr[1]), .ACC_CNT(acnt[1]));

  // Reference model: plain byte arrays, access counters, sticky error flags.
  logic [7:0] mdl_mem [2][4096];
  int         mdl_acc [2];
  bit         mdl_err [2];

  int checks   = 0;
  int failures = 0;

  function automatic int ws_of(input int sel);
    return (sel == 0) ? 0 : 3;
  endfunction

  function automatic bit wp_ok(input logic [15:0] a);
`ifdef MEM_RESPONDER_WPROT_EN
    return (a >= 16'h8000);
`else
    return (a == a);
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_access(input int sel, input bit we, input logic [15:0] a,
                              input logic [7:0] wd, output logic [7:0] exp);
    mdl_acc[sel] = (mdl_acc[sel] + 1) % 65536;
    exp = mdl_mem[sel][a[11:0]];
    if (we && wp_ok(a)) mdl_mem[sel][a[11:0]] = wd;
  endtask

  task automatic do_access(input int sel, input bit we, input logic [15:0] a,
                           input logic [7:0] wd, output logic [7:0] rdv, output int lat);
    @(negedge clk);
    mreq[sel] = 1'b1; rd[sel] = !we; wr[sel] = we;
    addr[sel] = a; dout[sel] = wd; den[sel] = we;
    @(posedge clk); #1;
    addr[sel] = ~a;   // must be ignored after capture
    lat = 0;
    while (!ready[sel] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rdv = (sel == 0) ? d0 : d1;
    @(negedge clk);
    mreq[sel] = 1'b0; rd[sel] = 1'b0; wr[sel] = 1'b0; den[sel] = 1'b0;
    @(posedge clk); #1;
    chk("ready_drop", 32'(ready[sel]), 32'd0);
  endtask

  task automatic run_one(input int sel, input bit we, input logic [15:0] a, input logic [7:0] wd);
    logic [7:0] rdv, exp;
    int lat;
    do_access(sel, we, a, wd, rdv, lat);
    model_access(sel, we, a, wd, exp);
    chk("latency", 32'(lat), 32'(ws_of(sel)));
    if (!we) chk("read_data", 32'(rdv), 32'(exp));
    chk("acc_cnt", 32'(acnt[sel]), 32'(mdl_acc[sel]));
  endtask

  typedef struct {
    int          sel;
    bit          we;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [7:0] rdv, exp_v;
    int lat, hi, first;

    tbl[0] = '{0, 1'b0, 16'h0100, 8'h00, 8'h00};
    tbl[1] = '{1, 1'b1, 16'h0010, 8'hA5, 8'h00};
    tbl[2] = '{1, 1'b0, 16'h0010, 8'h00, 8'hA5};
    tbl[3] = '{0, 1'b1, 16'h1005, 8'h3C, 8'h00};
    tbl[4] = '{0, 1'b0, 16'h0005, 8'h00, 8'h3C};
    tbl[5] = '{0, 1'b1, 16'hFFFF, 8'h5A, 8'h00};
    tbl[6] = '{0, 1'b0, 16'h0FFF, 8'h00, 8'h5A};
    tbl[7] = '{1, 1'b0, 16'h8010, 8'h00, 8'hA5};

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4096; i++) mdl_mem[s][i] = 8'h00;
      mdl_acc[s] = 0; mdl_err[s] = 1'b0;
      mreq[s] = 1'b0; rd[s] = 1'b0; wr[s] = 1'b0;
      addr[s] = 16'h0; dout[s] = 8'h0; den[s] = 1'b0;
    end

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", 32'(ready[s]), 32'd0);
      chk("rst_buserr", 32'(berr[s]), 32'd0);
      chk("rst_acc", 32'(acnt[s]), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      do_access(tbl[i].sel, tbl[i].we, tbl[i].a, tbl[i].wd, rdv, lat);
      model_access(tbl[i].sel, tbl[i].we, tbl[i].a, tbl[i].wd, exp_v);
`ifndef MEM_RESPONDER_WPROT_EN
      exp_v = tbl[i].exp;
`endif
      chk("vec_latency", 32'(lat), 32'(ws_of(tbl[i].sel)));
      if (!tbl[i].we) chk("vec_read", 32'(rdv), 32'(exp_v));
      chk("vec_acc", 32'(acnt[tbl[i].sel]), 32'(mdl_acc[tbl[i].sel]));
    end

    // Illegal strobe combination: sticky error, no capture
    @(negedge clk);
    mreq[0] = 1'b1; rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0123;
    repeat (3) begin
      @(posedge clk); #1;
      chk("err_ready", 32'(ready[0]), 32'd0);
    end
    mdl_err[0] = 1'b1;
    chk("err_set", 32'(berr[0]), 32'(mdl_err[0]));
    chk("err_acc", 32'(acnt[0]), 32'(mdl_acc[0]));
    @(negedge clk); mreq[0] = 1'b0; rd[0] = 1'b0; wr[0] = 1'b0;
    run_one(0, 1'b0, 16'h0005, 8'h00);
    chk("err_sticky", 32'(berr[0]), 32'(mdl_err[0]));

    // Reset pulsed in the second WAIT cycle aborts an uncommitted write
    @(negedge clk);
    mreq[1] = 1'b1; wr[1] = 1'b1; rd[1] = 1'b0; addr[1] = 16'h0020;
    dout[1] = 8'h77; den[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin mdl_acc[s] = 0; mdl_err[s] = 1'b0; end
    chk("rstw_ready", 32'(ready[1]), 32'd0);
    chk("rstw_acc1", 32'(acnt[1]), 32'(mdl_acc[1]));
    chk("rstw_acc0", 32'(acnt[0]), 32'(mdl_acc[0]));
    chk("rstw_err0", 32'(berr[0]), 32'(mdl_err[0]));
    mreq[1] = 1'b0; wr[1] = 1'b0; den[1] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_one(1, 1'b0, 16'h0020, 8'h00);
    chk("rstw_fill", 32'(mdl_mem[1][12'h020]), 32'h00);
    run_one(1, 1'b0, 16'h0010, 8'h00);   // array survives reset

    // MREQ dropped during WAIT: access completes with a one-cycle HOLD
    @(negedge clk);
    mreq[1] = 1'b1; rd[1] = 1'b1; wr[1] = 1'b0; addr[1] = 16'h0010;
    @(posedge clk);
    @(negedge clk); mreq[1] = 1'b0; rd[1] = 1'b0;
    hi = 0; first = -1;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(posedge clk);
      else @(posedge clk);
      #1;
      if (ready[1]) begin
        hi++;
        if (first < 0) first = i;
      end
    end
    model_access(1, 1'b0, 16'h0010, 8'h00, exp_v);
    chk("drop_first", 32'(first), 32'd3);
    chk("drop_len", 32'(hi), 32'd1);
    chk("drop_acc", 32'(acnt[1]), 32'(mdl_acc[1]));

`ifdef MEM_RESPONDER_WPROT_EN
    run_one(0, 1'b1, 16'h0000, 8'h11);
    run_one(0, 1'b1, 16'h9000, 8'h11);
    run_one(0, 1'b0, 16'h0000, 8'h00);
    run_one(0, 1'b0, 16'h9000, 8'h00);
`endif

    // Randomized traffic against the model, biased toward a small window
    for (int n = 0; n < 80; n++) begin
      int          sel;
      bit          we;
      logic [15:0] a;
      logic [7:0]  wd;
      sel = int'($urandom_range(1, 0));
      we  = 1'($urandom_range(1, 0));
      wd  = 8'($urandom);
      if ($urandom_range(1, 0) == 0) a = 16'($urandom);
      else a = {4'($urandom), 8'h00, 4'($urandom)};
      run_one(sel, we, a, wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
